rst_seq_mgr: RTL and testbench
==============================

// Module: rst_seq_mgr
// PURPOSE
//  Parametrised reset manager. Merges power-on, debug (NDM), programming and software
//  reset requests. Stretches the system reset for a minimum time, then releases
//  N_DOMAINS system reset domains one after another. Keeps a separate debug-domain reset
//  that only rst_ni affects, and records the reset cause in a sticky register.
//  Sits at top level between the pad reset/debug module and every system reset consumer.
// PARAMETERS
//  N_DOMAINS      3   number of sequenced system reset domains (>=1); released in order 0..N-1
//  STRETCH_CYCLES 16  minimum clk_i cycles all domains stay asserted after the last request (>=1)
//  RELEASE_GAP    4   clk_i cycles between consecutive domain releases (>=1)
//  SYNC_STAGES    2   synchroniser depth for ndm_rst_i, prog_rst_ni and dbg reset release (>=2)
// PORTS
//  clk_i           in   1          system clock
//  rst_ni          in   1          power-on reset, asynchronous, active-low
//  ndm_rst_i       in   1          debug-module non-debug reset request, async, active-high
//  prog_rst_ni     in   1          programming-mode reset request, async, active-low
//  sw_rst_req_i    in   1          software reset request, clk_i-synchronous, active-high
//  rst_cause_clr_i in   1          clears rst_cause_o, clk_i-synchronous pulse
//  sys_rst_no      out  N_DOMAINS  per-domain system reset, active-low, registered
//  dbg_rst_no      out  1          debug-domain reset, active-low, registered
//  busy_o          out  1          1 while any sys_rst_no bit is 0
//  rst_cause_o     out  4          sticky cause {sw, prog, ndm, por}
// BEHAVIOUR
//  Reset: rst_ni=0 asynchronously forces:
//   - sys_rst_no=0, dbg_rst_no=0, busy_o=1, rst_cause_o=4'b0001
//   - FSM=ASSERT, counters=0; synchroniser stages for ndm=0, prog=1
//  dbg_rst_no: asserts asynchronously on rst_ni. Deassertion goes through SYNC_STAGES flops,
//   so it rises on posedge SYNC_STAGES after rst_ni rises. No other input affects it.
//  Request: req = ndm_s | ~prog_s | sw_rst_req_i, where ndm_s/prog_s are the synchronised inputs.
//   - An async input change reaches ndm_s/prog_s SYNC_STAGES edges after it is first sampled.
//   - sys_rst_no goes to all-0 on the edge after req=1 is seen, whatever the FSM state.
//  FSM:
//   - ASSERT: sys_rst_no=0. Counter is held at 0 while req=1 and counts while req=0.
//     Moves to RELEASE after STRETCH_CYCLES consecutive req=0 cycles.
//   - RELEASE: domain 0 is released on the transition edge. Domain i is released
//     RELEASE_GAP edges after domain i-1; a released bit stays 1.
//     Moves to RUN on the edge that releases domain N-1.
//   - RUN: all sys_rst_no=1, busy_o=0. req=1 -> ASSERT.
//   - req=1 in RELEASE aborts the sequence: all bits go 0 and the stretch restarts from 0.
//  Timing after rst_ni rises with req=0 (edges numbered from 1):
//   - sys_rst_no[i] rises on edge STRETCH_CYCLES+1+i*RELEASE_GAP.
//   - Defaults: bits 0/1/2 rise on edges 17/21/25.
//  busy_o = ~&sys_rst_no, registered with the outputs.
//  Counter width: $clog2(max(STRETCH_CYCLES,RELEASE_GAP)+1). Saturates and never wraps.
//  rst_cause_o (bits 3..0 = {sw, prog, ndm, por}):
//   - a bit is set in the cycle its synchronised source requests; the por bit only by rst_ni
//   - clr=1 clears all bits; a set in the same cycle wins over the clear
//  Outputs are glitch-free flop outputs. sys_rst_no never releases out of order.
// TESTING
//  1 POR, defaults, no requests -> dbg_rst_no rises edge 2; sys_rst_no 000->001@17, 011@21, 111@25;
//    busy_o=0 from edge 25; cause=0001
//  2 In RUN, ndm_rst_i=1 for 5 cycles -> sys_rst_no=000 on edge 3 after first sample; dbg_rst_no stays 1;
//    bit0 rises 16 edges after synchronised ndm falls, then gaps of 4; cause bit1 set
//  3 sw_rst_req_i pulse in RUN -> sys_rst_no=000 next edge; full sequence repeats; cause bit3 set
//  4 sw pulse while bit1 released, bit2 pending -> all bits 0 next edge; stretch restarts from 0
//  5 prog_rst_ni held low 100 cycles -> outputs held 0 throughout; release 16 edges after prog_s rises
//  6 rst_cause_clr_i with sw_rst_req_i in same cycle -> cause=1000; clr alone later -> 0000;
//    rst_ni mid-RELEASE -> immediate all-0, cause=0001

Source files
------------

// File: rtl/rst_seq_mgr.sv
// Reset sequencing manager: merges POR, debug, programming and software reset requests,
// stretches the system reset, then releases the system domains in order 0..N-1.
module rst_seq_mgr #(
    parameter int N_DOMAINS      = 3,
    parameter int STRETCH_CYCLES = 16,
    parameter int RELEASE_GAP    = 4,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 ndm_rst_i,
    input  logic                 prog_rst_ni,
    input  logic                 sw_rst_req_i,
    input  logic                 rst_cause_clr_i,
    output logic [N_DOMAINS-1:0] sys_rst_no,
    output logic                 dbg_rst_no,
    output logic                 busy_o,
    output logic [3:0]           rst_cause_o
);

    localparam int CNT_MAX = (STRETCH_CYCLES > RELEASE_GAP) ? STRETCH_CYCLES : RELEASE_GAP;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int IW      = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [N_DOMAINS-1:0]   sys_rst_q, sys_rst_d;
    logic                   busy_q;
    logic [3:0]             cause_q, cause_d;
    logic [SYNC_STAGES-1:0] ndm_sync, prog_sync, dbg_sync;
    logic                   ndm_s, prog_s, req;

    // Synchronisers reset to the inactive request level so nothing fires on POR release.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ndm_sync  <= '0;
            prog_sync <= '1;
            dbg_sync  <= '0;
        end else begin
            ndm_sync  <= {ndm_sync[SYNC_STAGES-2:0], ndm_rst_i};
            prog_sync <= {prog_sync[SYNC_STAGES-2:0], prog_rst_ni};
            dbg_sync  <= {dbg_sync[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign ndm_s = ndm_sync[SYNC_STAGES-1];
    assign prog_s = prog_sync[SYNC_STAGES-1];
    assign req   = ndm_s | ~prog_s | sw_rst_req_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_ASSERT;
            cnt_q     <= '0;
            idx_q     <= '0;
            sys_rst_q <= '0;
            busy_q    <= 1'b1;
            cause_q   <= 4'b0001;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            sys_rst_q <= sys_rst_d;
            busy_q    <= ~&sys_rst_d;
            cause_q   <= cause_d;
        end
    end

    // idx tracks the highest domain already released while in RELEASE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        if (req) begin
            state_d = ST_ASSERT;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_ASSERT: begin
                    if (cnt_q >= CW'(STRETCH_CYCLES)) begin
                        cnt_d   = '0;
                        idx_d   = '0;
                        state_d = (N_DOMAINS == 1) ? ST_RUN : ST_RELEASE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_RELEASE: begin
                    if (cnt_q >= CW'(RELEASE_GAP - 1)) begin
                        cnt_d = '0;
                        idx_d = idx_q + IW'(1);
                        if (idx_q == IW'(N_DOMAINS - 2)) state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_RUN:  cnt_d = '0;
                default: state_d = ST_ASSERT;
            endcase
        end
    end

    // Outputs derive from the next state so every bit changes on the transition edge.
    always_comb begin
        sys_rst_d = '0;
        case (state_d)
            ST_RUN:     sys_rst_d = '1;
            ST_RELEASE: begin
                for (int i = 0; i < N_DOMAINS; i++) sys_rst_d[i] = (IW'(i) <= idx_d);
            end
            default:    sys_rst_d = '0;
        endcase
    end

    always_comb begin
        cause_d = rst_cause_clr_i ? 4'b0000 : cause_q;
        cause_d = cause_d | {sw_rst_req_i, ~prog_s, ndm_s, 1'b0};
    end

    assign sys_rst_no  = sys_rst_q;
    assign dbg_rst_no  = dbg_sync[SYNC_STAGES-1];
    assign busy_o      = busy_q;
    assign rst_cause_o = cause_q;

endmodule

// File: tb/tb_rst_seq_mgr.sv
// Directed bench for rst_seq_mgr with default parameters; expectations are derived from
// the edge-timing rules and queued ahead of each clock edge.
module tb_rst_seq_mgr;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ndm_rst;
    logic       prog_rst_n;
    logic       sw_rst_req;
    logic       cause_clr;
    logic [2:0] sys_rst_n;
    logic       dbg_rst_n;
    logic       busy;
    logic [3:0] rst_cause;

    logic [8:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rst_seq_mgr dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .ndm_rst_i      (ndm_rst),
        .prog_rst_ni    (prog_rst_n),
        .sw_rst_req_i   (sw_rst_req),
        .rst_cause_clr_i(cause_clr),
        .sys_rst_no     (sys_rst_n),
        .dbg_rst_no     (dbg_rst_n),
        .busy_o         (busy),
        .rst_cause_o    (rst_cause)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bit i rises on edge first + 4*i.
    function automatic logic [2:0] seq_bits(int e, int first);
        logic [2:0] r;
        for (int i = 0; i < 3; i++) r[i] = (e >= first + 4 * i);
        return r;
    endfunction

    function automatic logic [8:0] mk(logic [2:0] s, logic d, logic [3:0] c);
        return {s, d, (s != 3'b111), c};
    endfunction

    task automatic compare(string tag);
        logic [8:0] exp;
        logic [8:0] obs;
        n_tests++;
        obs = {sys_rst_n, dbg_rst_n, busy, rst_cause};
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL %s scoreboard empty obs=%b", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            assert (obs === exp)
            else begin
                n_fail++;
                $error("FAIL %s obs={sys,dbg,busy,cause}=%b exp=%b", tag, obs, exp);
            end
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        ndm_rst    = 1'b0;
        prog_rst_n = 1'b1;
        sw_rst_req = 1'b0;
        cause_clr  = 1'b0;
        repeat (3) tick();
        exp_q.push_back(mk(3'b000, 1'b0, 4'b0001));
        compare("reset_state");

        // POR release with no requests
        rst_n = 1'b1;
        for (int e = 1; e <= 26; e++) begin
            exp_q.push_back(mk(seq_bits(e, 17), (e >= 2), 4'b0001));
            tick();
            compare($sformatf("por e%0d", e));
        end

        // NDM request held for 5 samples while in RUN
        ndm_rst = 1'b1;
        for (int e = 1; e <= 33; e++) begin
            exp_q.push_back(mk((e < 3) ? 3'b111 : seq_bits(e, 24), 1'b1,
                               (e < 3) ? 4'b0001 : 4'b0011));
            tick();
            compare($sformatf("ndm e%0d", e));
            if (e == 5) ndm_rst = 1'b0;
        end

        // SW pulse in RUN, then a second pulse with bit1 released and bit2 pending
        sw_rst_req = 1'b1;
        for (int e = 1; e <= 50; e++) begin
            exp_q.push_back(mk((e < 24) ? seq_bits(e, 18) : seq_bits(e, 41), 1'b1, 4'b1011));
            tick();
            compare($sformatf("sw e%0d", e));
            if (e == 1 || e == 24) sw_rst_req = 1'b0;
            if (e == 23) sw_rst_req = 1'b1;
        end

        // Programming reset held low for 100 cycles
        prog_rst_n = 1'b0;
        for (int e = 1; e <= 128; e++) begin
            exp_q.push_back(mk((e < 3) ? 3'b111 : seq_bits(e, 119), 1'b1,
                               (e < 3) ? 4'b1011 : 4'b1111));
            tick();
            compare($sformatf("prog e%0d", e));
            if (e == 100) prog_rst_n = 1'b1;
        end

        // Clear together with a set, then clear alone
        sw_rst_req = 1'b1;
        cause_clr  = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            exp_q.push_back(mk(seq_bits(e, 18), 1'b1, (e < 6) ? 4'b1000 : 4'b0000));
            tick();
            compare($sformatf("clr e%0d", e));
            if (e == 1) begin
                sw_rst_req = 1'b0;
                cause_clr  = 1'b0;
            end
            if (e == 5) cause_clr = 1'b1;
            if (e == 6) cause_clr = 1'b0;
        end

        // POR asserted mid-RELEASE takes effect without a clock edge
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.push_back(mk(3'b000, 1'b0, 4'b0001));
        compare("por_async");
        repeat (2) tick();
        rst_n = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            exp_q.push_back(mk(3'b000, (e >= 2), 4'b0001));
            tick();
            compare($sformatf("por2 e%0d", e));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
